// File: rtl/uart_cmd_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_frame_parser
//
// Parses command frames arriving byte-by-byte from an even-parity UART receiver:
//   0xA5, 0x5A, CMD, LEN, LEN payload bytes, CHK
// where CHK is the XOR of CMD, LEN and every payload byte. A checked frame is
// held (cmd_valid high, rx_data_ready low) until the consumer pulses cmd_ack.
//
// Handshake: a byte is consumed on every rising clk edge where
// rx_data_valid && rx_data_ready; upstream holds rx_data/rx_data_valid until then.
//
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   rx_data         - byte from the UART receiver
//   rx_data_valid   - rx_data valid, held until accepted
//   rx_data_ready   - parser can take a byte (low only while a frame is held)
//   parity_err      - one-cycle pulse from the receiver, no byte delivered
//   cmd_valid       - a complete, checksum-verified frame is held
//   cmd_code        - CMD byte of the held frame
//   cmd_len         - payload length of the held frame
//   cmd_ack         - consumer releases the held frame
//   pl_rd_addr      - payload buffer read index
//   pl_rd_data      - payload byte at pl_rd_addr (combinational read)
//   frame_err       - one-cycle error pulse
//   err_code        - last error cause: 0 timeout, 1 parity, 2 length, 3 checksum
//   state_dbg       - current FSM state, for observation only
// -----------------------------------------------------------------------------
module uart_cmd_frame_parser #(
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 40000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    output logic       rx_data_ready,
    input  logic       parity_err,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [4:0] cmd_len,
    input  logic       cmd_ack,
    input  logic [3:0] pl_rd_addr,
    output logic [7:0] pl_rd_data,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR2    = 3'd1,
        S_CMD     = 3'd2,
        S_LEN     = 3'd3,
        S_PAYLOAD = 3'd4,
        S_CHK     = 3'd5,
        S_HOLD    = 3'd6
    } state_t;

    localparam logic [1:0]  ERR_TIMEOUT  = 2'd0;
    localparam logic [1:0]  ERR_PARITY   = 2'd1;
    localparam logic [1:0]  ERR_LENGTH   = 2'd2;
    localparam logic [1:0]  ERR_CHECKSUM = 2'd3;
    localparam logic [7:0]  MAX_LEN_B    = 8'(MAX_LEN);
    localparam logic [15:0] TMO_LAST     = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  chk;
    logic [3:0]  idx;
    logic [15:0] tmo_cnt;
    logic [7:0]  pl_buf [16];
    logic        accept;
    logic        active;

    assign rx_data_ready = (state != S_HOLD);
    assign accept        = rx_data_valid && rx_data_ready;
    // States in which a frame is in progress: parity and timeout abort here.
    assign active        = (state != S_IDLE) && (state != S_HOLD);
    assign pl_rd_data    = pl_buf[pl_rd_addr];
    assign state_dbg     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_valid <= 1'b0;
            cmd_code  <= 8'h00;
            cmd_len   <= 5'd0;
            frame_err <= 1'b0;
            err_code  <= ERR_TIMEOUT;
            chk       <= 8'h00;
            idx       <= 4'd0;
            tmo_cnt   <= 16'd0;
            for (int i = 0; i < 16; i++) begin
                pl_buf[i] <= 8'h00;
            end
        end else begin
            frame_err <= 1'b0;
            if (active && parity_err) begin
                // Parity wins over a byte accepted in the same cycle: the byte is dropped.
                state     <= S_IDLE;
                frame_err <= 1'b1;
                err_code  <= ERR_PARITY;
                chk       <= 8'h00;
                idx       <= 4'd0;
                tmo_cnt   <= 16'd0;
            end else if (active && !accept && tmo_cnt == TMO_LAST) begin
                state     <= S_IDLE;
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                chk       <= 8'h00;
                idx       <= 4'd0;
                tmo_cnt   <= 16'd0;
            end else begin
                // Every state entry inside a frame happens on an accepted byte,
                // so clearing on accept also clears on entry.
                if (active) begin
                    tmo_cnt <= accept ? 16'd0 : tmo_cnt + 16'd1;
                end
                case (state)
                    S_IDLE: begin
                        if (accept && rx_data == 8'hA5) begin
                            state   <= S_HDR2;
                            tmo_cnt <= 16'd0;
                        end
                    end
                    S_HDR2: begin
                        if (accept) begin
                            if (rx_data == 8'h5A) begin
                                state <= S_CMD;
                            end else if (rx_data != 8'hA5) begin
                                state <= S_IDLE;   // noise, silently dropped
                            end
                        end
                    end
                    S_CMD: begin
                        if (accept) begin
                            cmd_code <= rx_data;
                            chk      <= rx_data;
                            state    <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (accept) begin
                            if (rx_data > MAX_LEN_B) begin
                                state     <= S_IDLE;
                                frame_err <= 1'b1;
                                err_code  <= ERR_LENGTH;
                                chk       <= 8'h00;
                                tmo_cnt   <= 16'd0;
                            end else begin
                                cmd_len <= rx_data[4:0];
                                chk     <= chk ^ rx_data;
                                idx     <= 4'd0;
                                state   <= (rx_data == 8'h00) ? S_CHK : S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (accept) begin
                            pl_buf[idx] <= rx_data;
                            chk         <= chk ^ rx_data;
                            if ({1'b0, idx} == cmd_len - 5'd1) begin
                                idx   <= 4'd0;
                                state <= S_CHK;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                    S_CHK: begin
                        if (accept) begin
                            chk     <= 8'h00;
                            tmo_cnt <= 16'd0;
                            if (rx_data == chk) begin
                                cmd_valid <= 1'b1;
                                state     <= S_HOLD;
                            end else begin
                                frame_err <= 1'b1;
                                err_code  <= ERR_CHECKSUM;
                                state     <= S_IDLE;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (cmd_ack) begin
                            cmd_valid <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
